// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types, including the L2 arbiter state and port encodings.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RECOVER
  } l2_arb_state_t;

  typedef enum logic {
    ARB_I,
    ARB_D
  } l2_arb_port_t;

endpackage

// File: rtl/l2_arbiter.sv
// Shares the single L2 port between the I-cache miss path and the D-cache miss/writeback path.
// Define L2_ARB_ROUND_ROBIN_EN to alternate tie-breaks; otherwise D always wins ties.
//
// state   | meaning
// IDLE    | no grant; sample requests and pick a winner
// SERVE_I | I-side owns L2 until l2_resp
// SERVE_D | D-side owns L2 until l2_resp
// RECOVER | dead cycle so the served requester can drop its request
module l2_arbiter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     icache_pmem_read,
  input  lc3b_word icache_pmem_address,
  output logic     icache_pmem_resp,
  output lc3b_line icache_pmem_rdata,
  input  logic     dcache_pmem_read,
  input  logic     dcache_pmem_write,
  input  lc3b_word dcache_pmem_address,
  input  lc3b_line dcache_pmem_wdata,
  output logic     dcache_pmem_resp,
  output lc3b_line dcache_pmem_rdata,
  output logic     l2_read,
  output logic     l2_write,
  output lc3b_word l2_address,
  output lc3b_line l2_wdata,
  input  logic     l2_resp,
  input  lc3b_line l2_rdata
);

  l2_arb_state_t state_q, state_d;
  l2_arb_port_t  last_grant_q, last_grant_d;
  l2_arb_state_t tie_state;
  logic          i_req, d_req;

  assign i_req = icache_pmem_read;
  assign d_req = dcache_pmem_read | dcache_pmem_write;

`ifdef L2_ARB_ROUND_ROBIN_EN
  assign tie_state = (last_grant_q == ARB_I) ? SERVE_D : SERVE_I;
`else
  assign tie_state = SERVE_D;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= ARB_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    l2_read          = 1'b0;
    l2_write         = 1'b0;
    l2_address       = '0;
    l2_wdata         = '0;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) state_d = tie_state;
        else if (d_req)     state_d = SERVE_D;
        else if (i_req)     state_d = SERVE_I;
      end
      SERVE_I: begin
        l2_read          = icache_pmem_read;
        l2_address       = icache_pmem_address;
        icache_pmem_resp = l2_resp;
        if (l2_resp) begin
          last_grant_d = ARB_I;
          state_d      = RECOVER;
        end
      end
      SERVE_D: begin
        // a simultaneous read+write is treated as a writeback
        l2_write         = dcache_pmem_write;
        l2_read          = dcache_pmem_read & ~dcache_pmem_write;
        l2_address       = dcache_pmem_address;
        l2_wdata         = dcache_pmem_wdata;
        dcache_pmem_resp = l2_resp;
        if (l2_resp) begin
          last_grant_d = ARB_D;
          state_d      = RECOVER;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign icache_pmem_rdata = l2_rdata;
  assign dcache_pmem_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Randomized self-checking bench for l2_arbiter against a grant-order reference model.
module tb_l2_arbiter;
  import lc3b_types::*;

  logic     clk = 1'b0;
  logic     reset_n;
  logic     icache_pmem_read;
  lc3b_word icache_pmem_address;
  logic     icache_pmem_resp;
  lc3b_line icache_pmem_rdata;
  logic     dcache_pmem_read;
  logic     dcache_pmem_write;
  lc3b_word dcache_pmem_address;
  lc3b_line dcache_pmem_wdata;
  logic     dcache_pmem_resp;
  lc3b_line dcache_pmem_rdata;
  logic     l2_read;
  logic     l2_write;
  lc3b_word l2_address;
  lc3b_line l2_wdata;
  logic     l2_resp;
  lc3b_line l2_rdata;

  int cmp = 0;
  int err = 0;
  l2_arb_port_t model_last = ARB_I;

  l2_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .icache_pmem_read(icache_pmem_read), .icache_pmem_address(icache_pmem_address),
    .icache_pmem_resp(icache_pmem_resp), .icache_pmem_rdata(icache_pmem_rdata),
    .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
    .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
    .dcache_pmem_resp(dcache_pmem_resp), .dcache_pmem_rdata(dcache_pmem_rdata),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic lc3b_line rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Who should win the next grant, given who is requesting.
  function automatic l2_arb_port_t pick(input bit i, input bit d);
    if (i && d) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
      return (model_last == ARB_I) ? ARB_D : ARB_I;
`else
      return ARB_D;
`endif
    end
    return d ? ARB_D : ARB_I;
  endfunction

  // Runs one L2 transaction for port p, ending in the IDLE cycle after RECOVER.
  task automatic do_txn(input l2_arb_port_t p, input int delay, input lc3b_line rd,
                        input bit hold, input bit raise_d);
    int       waited;
    logic     exp_r, exp_w;
    lc3b_word exp_a;
    lc3b_line exp_wd;
    waited = 0;
    while (!(l2_read || l2_write) && waited < 8) begin
      step();
      waited++;
    end
    cmp++;
    if (!(l2_read || l2_write)) begin
      err++;
      $display("FAIL grant_timeout: no L2 strobe after %0d cycles, required grant to port %0d", waited, p);
      return;
    end
    if (p == ARB_I) begin
      exp_r = 1'b1; exp_w = 1'b0; exp_a = icache_pmem_address; exp_wd = '0;
    end else begin
      exp_w = dcache_pmem_write; exp_r = dcache_pmem_read & ~dcache_pmem_write;
      exp_a = dcache_pmem_address; exp_wd = dcache_pmem_wdata;
    end
    cmp++;
    if ({l2_read, l2_write, l2_address, l2_wdata} !== {exp_r, exp_w, exp_a, exp_wd}) begin
      err++;
      $display("FAIL grant_drive: got rd=%b wr=%b a=%h wd=%h, required rd=%b wr=%b a=%h wd=%h (port %0d)",
               l2_read, l2_write, l2_address, l2_wdata, exp_r, exp_w, exp_a, exp_wd, p);
    end
    if (raise_d) begin
      dcache_pmem_read    = 1'b1;
      dcache_pmem_write   = 1'b0;
      dcache_pmem_address = lc3b_word'($urandom);
      dcache_pmem_wdata   = rand_line();
    end
    for (int k = 0; k < delay; k++) begin
      step();
      cmp++;
      if ({icache_pmem_resp, dcache_pmem_resp} !== 2'b00) begin
        err++;
        $display("FAIL resp_early: got i=%b d=%b, required 0 0", icache_pmem_resp, dcache_pmem_resp);
      end
    end
    l2_resp  = 1'b1;
    l2_rdata = rd;
    #1;
    cmp++;
    if ({icache_pmem_resp, dcache_pmem_resp} !== ((p == ARB_I) ? 2'b10 : 2'b01)) begin
      err++;
      $display("FAIL resp_route: got i=%b d=%b, required port %0d only", icache_pmem_resp, dcache_pmem_resp, p);
    end
    cmp++;
    if (((p == ARB_I) ? icache_pmem_rdata : dcache_pmem_rdata) !== rd) begin
      err++;
      $display("FAIL rdata: got %h, required %h", (p == ARB_I) ? icache_pmem_rdata : dcache_pmem_rdata, rd);
    end
    step();
    l2_resp    = 1'b0;
    model_last = p;
    if (!hold) begin
      if (p == ARB_I) icache_pmem_read = 1'b0;
      else begin dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0; end
    end
    if ($urandom_range(0, 1) == 1) l2_resp = 1'b1;
    #1;
    cmp++;
    if ({l2_read, l2_write, l2_address, icache_pmem_resp, dcache_pmem_resp} !== '0) begin
      err++;
      $display("FAIL recover: got rd=%b wr=%b a=%h ir=%b dr=%b, required all 0 (stray resp=%b)",
               l2_read, l2_write, l2_address, icache_pmem_resp, dcache_pmem_resp, l2_resp);
    end
    l2_resp = 1'b0;
    step();
    cmp++;
    if ({l2_read, l2_write} !== 2'b00) begin
      err++;
      $display("FAIL idle_after_recover: got rd=%b wr=%b, required 0 0", l2_read, l2_write);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    icache_pmem_read = 1'b1; icache_pmem_address = 16'h1110;
    dcache_pmem_read = 1'b1; dcache_pmem_write = 1'b0; dcache_pmem_address = 16'h2220;
    dcache_pmem_wdata = rand_line();
    step(); step();
    cmp++;
    if ({l2_read, l2_write, l2_address, l2_wdata, icache_pmem_resp, dcache_pmem_resp} !== '0) begin
      err++;
      $display("FAIL reset_state: got rd=%b wr=%b a=%h ir=%b dr=%b, required all 0",
               l2_read, l2_write, l2_address, icache_pmem_resp, dcache_pmem_resp);
    end
    reset_n = 1'b1;
    model_last = ARB_I;
    do_txn(pick(1'b1, 1'b1), 1, rand_line(), 1'b0, 1'b0);
    do_txn(pick(icache_pmem_read, dcache_pmem_read), 0, rand_line(), 1'b0, 1'b0);
  endtask

  task automatic test_lone_i();
    icache_pmem_read = 1'b1; icache_pmem_address = 16'h3020;
    do_txn(ARB_I, 4, {16{8'hA5}}, 1'b0, 1'b0);
  endtask

  task automatic test_d_write();
    dcache_pmem_write = 1'b1; dcache_pmem_address = 16'h4040;
    dcache_pmem_wdata = 128'h1234_5678_9abc_def0_1234_5678_9abc_def0;
    do_txn(ARB_D, 2, rand_line(), 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    l2_arb_port_t w;
    icache_pmem_read = 1'b1; icache_pmem_address = 16'h5000;
    dcache_pmem_read = 1'b1; dcache_pmem_address = 16'h6000; dcache_pmem_wdata = rand_line();
    for (int k = 0; k < 4; k++) begin
      w = pick(icache_pmem_read, dcache_pmem_read | dcache_pmem_write);
      do_txn(w, $urandom_range(0, 2), rand_line(), (w == ARB_I) || (k != 1), 1'b0);
    end
    icache_pmem_read = 1'b0; dcache_pmem_read = 1'b0;
  endtask

  task automatic test_mid_request();
    icache_pmem_read = 1'b1; icache_pmem_address = 16'h7010;
    do_txn(ARB_I, 2, rand_line(), 1'b0, 1'b1);
    do_txn(pick(icache_pmem_read, dcache_pmem_read), 1, rand_line(), 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_serve();
    dcache_pmem_read = 1'b1; dcache_pmem_address = 16'h8080; dcache_pmem_wdata = rand_line();
    step();
    cmp++;
    if (l2_read !== 1'b1) begin
      err++;
      $display("FAIL serve_d_start: got rd=%b, required 1", l2_read);
    end
    reset_n = 1'b0;
    step();
    cmp++;
    if ({l2_read, l2_write, dcache_pmem_resp} !== 3'b000) begin
      err++;
      $display("FAIL reset_mid_serve: got rd=%b wr=%b dr=%b, required 0 0 0", l2_read, l2_write, dcache_pmem_resp);
    end
    reset_n = 1'b1;
    model_last = ARB_I;
    l2_resp = 1'b1;
    #1;
    cmp++;
    if ({icache_pmem_resp, dcache_pmem_resp} !== 2'b00) begin
      err++;
      $display("FAIL stray_resp: got i=%b d=%b, required 0 0", icache_pmem_resp, dcache_pmem_resp);
    end
    l2_resp = 1'b0;
    do_txn(ARB_D, 1, rand_line(), 1'b0, 1'b0);
  endtask

  task automatic test_random();
    l2_arb_port_t w;
    for (int n = 0; n < 40; n++) begin
      if (!icache_pmem_read && $urandom_range(0, 1) == 1) begin
        icache_pmem_read = 1'b1; icache_pmem_address = lc3b_word'($urandom);
      end
      if (!(dcache_pmem_read || dcache_pmem_write) && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) dcache_pmem_write = 1'b1;
        else dcache_pmem_read = 1'b1;
        dcache_pmem_address = lc3b_word'($urandom);
        dcache_pmem_wdata   = rand_line();
      end
      if (!icache_pmem_read && !(dcache_pmem_read || dcache_pmem_write)) begin
        step();
        cmp++;
        if ({l2_read, l2_write, icache_pmem_resp, dcache_pmem_resp} !== 4'b0000) begin
          err++;
          $display("FAIL idle_quiet: got rd=%b wr=%b ir=%b dr=%b, required 0", l2_read, l2_write,
                   icache_pmem_resp, dcache_pmem_resp);
        end
        continue;
      end
      w = pick(icache_pmem_read, dcache_pmem_read | dcache_pmem_write);
      do_txn(w, $urandom_range(0, 3), rand_line(), 1'b0, 1'b0);
    end
    icache_pmem_read = 1'b0; dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    icache_pmem_read = 1'b0; icache_pmem_address = '0;
    dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
    dcache_pmem_address = '0; dcache_pmem_wdata = '0;
    l2_resp = 1'b0; l2_rdata = '0;
    test_reset();
    test_lone_i();
    test_d_write();
    test_back_to_back();
    test_mid_request();
    test_reset_mid_serve();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
